// File: rtl/fpu_mul_iter16.sv
`default_nettype none
// ============================================================================
// Module      : fpu_mul_iter16
// Description : Iterative FP16 multiplier. The significand product is formed
//               by 11 shift-and-add steps. The exact 22-bit product, its
//               exponent and its denormal shift are presented unnormalized
//               to a downstream normalizer. NaN, infinity and zero operands
//               are resolved on the accepting edge and returned as a final
//               value on specialOut.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_mul_iter16 #(
  parameter int EXP_BIAS = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        inValid,
  output logic        inReady,
  input  logic [15:0] fpuIn1,
  input  logic [15:0] fpuIn2,
  output logic        outValid,
  input  logic        outReady,
  output logic        unnormSign,
  output logic [1:0]  unnormInt,
  output logic [19:0] unnormFrac,
  output logic [4:0]  unnormExp,
  output logic [9:0]  denormDiff,
  output logic        sticky,
  output logic        OFin,
  output logic        special,
  output logic [15:0] specialOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operand field decode
  logic       a_sign, b_sign;
  logic [4:0] a_exp, b_exp;
  logic [9:0] a_frac, b_frac;
  logic       a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic       is_special;
  logic       prod_sign;
  logic       accept;

  assign a_sign = fpuIn1[15];
  assign a_exp  = fpuIn1[14:10];
  assign a_frac = fpuIn1[9:0];
  assign b_sign = fpuIn2[15];
  assign b_exp  = fpuIn2[14:10];
  assign b_frac = fpuIn2[9:0];

  assign a_nan  = (&a_exp) & (|a_frac);
  assign b_nan  = (&b_exp) & (|b_frac);
  assign a_inf  = (&a_exp) & ~(|a_frac);
  assign b_inf  = (&b_exp) & ~(|b_frac);
  assign a_zero = ~(|fpuIn1[14:0]);
  assign b_zero = ~(|fpuIn2[14:0]);

  assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
  assign prod_sign  = a_sign ^ b_sign;

  // Handshake: never ready while reset is held, only ready in IDLE
  assign inReady  = reset_n & (state == IDLE);
  assign outValid = (state == DONE);
  assign accept   = inValid & inReady;

  // Final value for NaN / infinity / zero operand combinations
  logic [15:0] special_val;

  // Select the special result; NaN dominates, then inf x zero is invalid
  always_comb begin
    special_val = 16'h0000;
    if (a_nan | b_nan) begin
      special_val = 16'h7E00;
    end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
      special_val = 16'h7E00;
    end else if (a_inf | b_inf) begin
      special_val = {prod_sign, 5'h1F, 10'd0};
    end else if (a_zero | b_zero) begin
      special_val = {prod_sign, 15'd0};
    end
  end

  // Exponent arithmetic: subnormals use an effective exponent of 1
  logic [4:0]        a_eff, b_eff;
  logic signed [6:0] exp_sum;
  logic [7:0]        exp_neg;
  logic [4:0]        exp_field;
  logic [9:0]        diff_field;
  logic              of_field;

  assign a_eff   = (a_exp == 5'd0) ? 5'd1 : a_exp;
  assign b_eff   = (b_exp == 5'd0) ? 5'd1 : b_exp;
  assign exp_sum = $signed({2'b00, a_eff}) + $signed({2'b00, b_eff})
                 - $signed(7'(EXP_BIAS));
  // Negation done one bit wider so that the most negative sum cannot wrap
  assign exp_neg = 8'd0 - {exp_sum[6], exp_sum};

  // Classify the exponent into in-range, overflow or denormal shift
  always_comb begin
    exp_field  = exp_sum[4:0];
    diff_field = 10'd0;
    of_field   = 1'b0;
    if (exp_sum > 7'sd30) begin
      of_field  = 1'b1;
      exp_field = 5'h1F;
    end else if (exp_sum < 7'sd1) begin
      exp_field  = 5'd0;
      diff_field = (exp_neg > 8'd24) ? 10'd24 : {2'b00, exp_neg};
    end
  end

  // Multiplier datapath registers
  logic [10:0] sig_a, sig_b;
  logic [21:0] acc;
  logic [3:0]  count;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_special ? DONE : MUL;
      MUL:  if (count == 4'd10) state_nxt = DONE;
      DONE: if (outValid & outReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, shift-and-add iteration and result field registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sig_a      <= 11'd0;
      sig_b      <= 11'd0;
      acc        <= 22'd0;
      count      <= 4'd0;
      unnormSign <= 1'b0;
      unnormExp  <= 5'd0;
      denormDiff <= 10'd0;
      OFin       <= 1'b0;
      special    <= 1'b0;
      specialOut <= 16'h0000;
    end else if (accept) begin
      sig_a      <= {|a_exp, a_frac};
      sig_b      <= {|b_exp, b_frac};
      acc        <= 22'd0;
      count      <= 4'd0;
      unnormSign <= prod_sign;
      special    <= is_special;
      specialOut <= is_special ? special_val : 16'h0000;
      unnormExp  <= is_special ? 5'd0  : exp_field;
      denormDiff <= is_special ? 10'd0 : diff_field;
      OFin       <= is_special ? 1'b0  : of_field;
    end else if (state == MUL) begin
      if (sig_b[count]) begin
        acc <= acc + (22'(sig_a) << count);
      end
      count <= count + 4'd1;
    end
  end

  // The product is exact, so nothing is ever shifted out
  assign sticky     = 1'b0;
  assign unnormInt  = acc[21:20];
  assign unnormFrac = acc[19:0];

endmodule
`default_nettype wire

// File: tb/tb_fpu_mul_iter16.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_mul_iter16
// Description : Self-checking bench for fpu_mul_iter16 with a behavioural
//               reference model built from integer multiplication.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_mul_iter16;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic [15:0] fpuIn1 = 16'h0000;
  logic [15:0] fpuIn2 = 16'h0000;
  logic        inReady, outValid, unnormSign, sticky, OFin, special;
  logic [1:0]  unnormInt;
  logic [19:0] unnormFrac;
  logic [4:0]  unnormExp;
  logic [9:0]  denormDiff;
  logic [15:0] specialOut;

  int checks = 0;
  int errors = 0;

  fpu_mul_iter16 #(.EXP_BIAS(15)) dut (
    .clock(clock), .reset_n(reset_n),
    .inValid(inValid), .inReady(inReady),
    .fpuIn1(fpuIn1), .fpuIn2(fpuIn2),
    .outValid(outValid), .outReady(outReady),
    .unnormSign(unnormSign), .unnormInt(unnormInt), .unnormFrac(unnormFrac),
    .unnormExp(unnormExp), .denormDiff(denormDiff), .sticky(sticky),
    .OFin(OFin), .special(special), .specialOut(specialOut)
  );

  always #5 clock = ~clock;

  // Packed view of every result field: special, specialOut, int, frac, exp, diff, OFin, sticky
  logic [55:0] got;
  assign got = {special, specialOut, unnormInt, unnormFrac, unnormExp, denormDiff, OFin, sticky};

  // Reference model: classify operands, multiply significands as integers
  function automatic logic [55:0] model(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, fa, fb, ma, mb, p, e, ie, id, io;
    logic s, nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    s  = a[15] ^ b[15];
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    nan_a = (ea == 31) && (fa != 0); nan_b = (eb == 31) && (fb != 0);
    inf_a = (ea == 31) && (fa == 0); inf_b = (eb == 31) && (fb == 0);
    z_a   = (ea == 0) && (fa == 0);  z_b   = (eb == 0) && (fb == 0);
    if (nan_a || nan_b) return {1'b1, 16'h7E00, 39'd0};
    if ((inf_a && z_b) || (inf_b && z_a)) return {1'b1, 16'h7E00, 39'd0};
    if (inf_a || inf_b) return {1'b1, s, 5'h1F, 10'd0, 39'd0};
    if (z_a || z_b) return {1'b1, s, 15'd0, 39'd0};
    ma = (ea != 0 ? 1024 : 0) + fa;
    mb = (eb != 0 ? 1024 : 0) + fb;
    p  = ma * mb;
    e  = (ea == 0 ? 1 : ea) + (eb == 0 ? 1 : eb) - 15;
    if (e > 30) begin ie = 31; id = 0; io = 1; end
    else if (e < 1) begin ie = 0; id = (-e > 24) ? 24 : -e; io = 0; end
    else begin ie = e; id = 0; io = 0; end
    return {1'b0, 16'h0000, 2'(p / 1048576), 20'(p % 1048576), 5'(ie), 10'(id), 1'(io), 1'b0};
  endfunction

  // Random operand with a bias towards the interesting classes
  function automatic logic [15:0] rand_fp();
    logic [15:0] v;
    int k;
    v = 16'($urandom);
    k = int'($urandom_range(0, 9));
    case (k)
      0: v[14:10] = 5'h1F;
      1: v[14:0]  = {5'h1F, 10'd0};
      2: v[14:0]  = 15'd0;
      3: v[14:10] = 5'd0;
      default: v[14:10] = 5'($urandom_range(1, 30));
    endcase
    return v;
  endfunction

  // Present one operation and wait (bounded) for outValid; lat counts falling edges after issue
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    int n;
    n = 0;
    while (!inReady && n < 50) begin @(negedge clock); n++; end
    fpuIn1 = a; fpuIn2 = b; inValid = 1'b1;
    @(negedge clock);
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 40) begin @(negedge clock); lat++; end
  endtask

  task automatic finish_op();
    outReady = 1'b1;
    @(negedge clock);
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL reset_inready got=%b exp=0", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outvalid got=%b exp=0", outValid); end
    repeat (3) @(negedge clock);
    checks++; if (got !== 56'd0) begin errors++; $display("FAIL reset_fields got=%h exp=0", got); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL reset_held_inready got=%b exp=0", inReady); end
    reset_n = 1'b1;
    @(negedge clock);
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL post_reset_inready got=%b exp=1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL post_reset_outvalid got=%b exp=0", outValid); end
  endtask

  logic [15:0] dir_a [10] = '{16'h3C00, 16'h3E00, 16'h7BFF, 16'h0001, 16'h7E00,
                              16'h7C00, 16'h7C00, 16'h8000, 16'hC000, 16'h3555};
  logic [15:0] dir_b [10] = '{16'h3C00, 16'h3E00, 16'h7BFF, 16'h0001, 16'h3C00,
                              16'h0000, 16'hC000, 16'h3C00, 16'h4400, 16'h0200};

  task automatic test_directed();
    int lat, exp_lat;
    logic [55:0] exp;
    for (int i = 0; i < 10; i++) begin
      do_op(dir_a[i], dir_b[i], lat);
      exp = model(dir_a[i], dir_b[i]);
      exp_lat = exp[55] ? 1 : 12;
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL dir_latency %h*%h got=%0d exp=%0d", dir_a[i], dir_b[i], lat, exp_lat); end
      checks++; if (got !== exp) begin errors++; $display("FAIL dir_fields %h*%h got=%h exp=%h", dir_a[i], dir_b[i], got, exp); end
      checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL dir_inready_done got=%b exp=0", inReady); end
      if (!exp[55]) begin
        checks++; if (unnormSign !== (dir_a[i][15] ^ dir_b[i][15])) begin errors++; $display("FAIL dir_sign got=%b exp=%b", unnormSign, dir_a[i][15] ^ dir_b[i][15]); end
      end
      if (i == 0) begin
        checks++; if (got !== {1'b0, 16'h0, 2'b01, 20'h0, 5'd15, 10'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL one_times_one got=%h", got); end
      end
      if (i == 3) begin
        checks++; if (denormDiff !== 10'd13 || unnormExp !== 5'd0) begin errors++; $display("FAIL tiny_denorm got diff=%0d exp=%0d required diff=13 exp=0", denormDiff, unnormExp); end
      end
      finish_op();
    end
  endtask

  task automatic test_random();
    int lat, exp_lat;
    logic [15:0] a, b;
    logic [55:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = rand_fp(); b = rand_fp();
      do_op(a, b, lat);
      exp = model(a, b);
      exp_lat = exp[55] ? 1 : 12;
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd_latency %h*%h got=%0d exp=%0d", a, b, lat, exp_lat); end
      checks++; if (got !== exp) begin errors++; $display("FAIL rnd_fields %h*%h got=%h exp=%h", a, b, got, exp); end
      if (!exp[55]) begin
        checks++; if (unnormSign !== (a[15] ^ b[15])) begin errors++; $display("FAIL rnd_sign %h*%h got=%b", a, b, unnormSign); end
      end
      finish_op();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [55:0] held;
    do_op(16'h3C00, 16'h4000, lat);
    held = got;
    checks++; if (held !== model(16'h3C00, 16'h4000)) begin errors++; $display("FAIL bp_first got=%h exp=%h", held, model(16'h3C00, 16'h4000)); end
    fpuIn1 = 16'h3E00; fpuIn2 = 16'h3E00; inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (outValid !== 1'b1 || inReady !== 1'b0 || got !== held) begin
        errors++; $display("FAIL bp_hold cyc=%0d got v=%b r=%b f=%h exp v=1 r=0 f=%h", i, outValid, inReady, got, held); end
    end
    outReady = 1'b1;
    @(negedge clock);
    outReady = 1'b0;
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b r=%b exp v=0 r=1", outValid, inReady); end
    @(negedge clock);
    inValid = 1'b0;
    lat = 1;
    while (!outValid && lat < 40) begin @(negedge clock); lat++; end
    checks++; if (lat !== 12) begin errors++; $display("FAIL bp_second_latency got=%0d exp=12", lat); end
    checks++; if (got !== model(16'h3E00, 16'h3E00)) begin errors++; $display("FAIL bp_second got=%h exp=%h", got, model(16'h3E00, 16'h3E00)); end
    finish_op();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    fpuIn1 = 16'h3C00; fpuIn2 = 16'h3C00; inValid = 1'b1;
    @(negedge clock);
    inValid = 1'b0;
    repeat (5) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0 || inReady !== 1'b0 || got !== 56'd0) begin
      errors++; $display("FAIL mid_reset got v=%b r=%b f=%h exp v=0 r=0 f=0", outValid, inReady, got); end
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin @(negedge clock); if (outValid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_reset_spurious got=%b exp=0", seen); end
    do_op(16'h3C00, 16'h4000, lat);
    checks++; if (got !== {1'b0, 16'h0, 2'b01, 20'h0, 5'd16, 10'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL after_reset_op got=%h", got); end
    // Reset while holding a finished result
    #1 reset_n = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL done_reset got=%b exp=0", outValid); end
    @(negedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin errors++; $display("FAIL done_reset_idle got v=%b r=%b exp v=0 r=1", outValid, inReady); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
